// File: rtl/csa_tree_accum_if.sv
// Operand/result bundle for csa_tree_accum. The producer side uses the
// master modport, the reduction block uses the slave modport.
interface csa_tree_accum_if #(
    parameter int OP_WIDTH = 27,
    parameter int OP_NUM   = 32,
    parameter int ACC_EXT  = 4
);
    localparam int RES_W = OP_WIDTH + $clog2(OP_NUM) + ACC_EXT;
    localparam int LZ_W  = $clog2(RES_W + 1);

    logic                       in_valid;
    logic                       in_last;
    logic                       signed_mode;
    logic [OP_NUM*OP_WIDTH-1:0] ops_in;
    logic                       out_valid;
    logic [RES_W-1:0]           result;
    logic [LZ_W-1:0]            lz_out;
    logic                       overflow;
    logic [7:0]                 beat_cnt;

    modport master (
        output in_valid, in_last, signed_mode, ops_in,
        input  out_valid, result, lz_out, overflow, beat_cnt
    );

    modport slave (
        input  in_valid, in_last, signed_mode, ops_in,
        output out_valid, result, lz_out, overflow, beat_cnt
    );
endinterface

// File: rtl/csa_tree_accum.sv
// csa_tree_accum: zero-padded 4:2 compressor tree with configurable register
// banks, a carry-propagate stage and a group accumulator that emits one
// result per group with a leading zero/sign count and a sticky overflow.
module csa_tree_accum #(
    parameter int OP_WIDTH   = 27,
    parameter int OP_NUM     = 32,
    parameter int PIPE_EVERY = 1,
    parameter int ACC_EXT    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    csa_tree_accum_if.slave bus
);
    localparam int LOG_P2 = $clog2(OP_NUM);
    localparam int P2     = 1 << LOG_P2;
    localparam int LEVELS = LOG_P2 - 1;
    localparam int RES_W  = OP_WIDTH + LOG_P2 + ACC_EXT;
    localparam int LZ_W   = $clog2(RES_W + 1);

    // Sum output of a 4:2 compressor built from two chained 3:2 adders.
    function automatic logic [RES_W-1:0] csa42_sum(input logic [RES_W-1:0] a, b, c, d);
        logic [RES_W-1:0] s1, c1;
        s1 = a ^ b ^ c;
        c1 = ((a & b) | (a & c) | (b & c)) << 1;
        return s1 ^ c1 ^ d;
    endfunction

    // Carry output of the same compressor; bits beyond RES_W are dropped.
    function automatic logic [RES_W-1:0] csa42_carry(input logic [RES_W-1:0] a, b, c, d);
        logic [RES_W-1:0] s1, c1;
        s1 = a ^ b ^ c;
        c1 = ((a & b) | (a & c) | (b & c)) << 1;
        return ((s1 & c1) | (s1 & d) | (c1 & d)) << 1;
    endfunction

    // Leading zeros (unsigned) or redundant sign bits (signed, count minus one).
    function automatic logic [LZ_W-1:0] lead_count(input logic [RES_W-1:0] v, input logic sgn);
        logic ref_b;
        logic run;
        int   n;
        ref_b = sgn ? v[RES_W-1] : 1'b0;
        run   = 1'b1;
        n     = 0;
        for (int i = RES_W - 1; i >= 0; i--) begin
            if (run && (v[i] == ref_b)) n = n + 1;
            else                        run = 1'b0;
        end
        return LZ_W'(sgn ? n - 1 : n);
    endfunction

    logic [RES_W-1:0] w_stage [0:LEVELS][0:P2-1];
    logic             w_vld   [0:LEVELS];
    logic             w_lst   [0:LEVELS];
    logic             w_sgn   [0:LEVELS];

    assign w_vld[0] = bus.in_valid;
    assign w_lst[0] = bus.in_valid & bus.in_last;
    assign w_sgn[0] = bus.signed_mode;

    // Operand extension; lanes past OP_NUM are padding and stay zero.
    for (genvar i = 0; i < P2; i++) begin : g_ext
        if (i < OP_NUM) begin : g_op
            logic [OP_WIDTH-1:0] w_op;
            assign w_op          = bus.ops_in[i*OP_WIDTH +: OP_WIDTH];
            assign w_stage[0][i] = {{(RES_W-OP_WIDTH){bus.signed_mode & w_op[OP_WIDTH-1]}}, w_op};
        end else begin : g_pad
            assign w_stage[0][i] = '0;
        end
    end

    for (genvar j = 1; j <= LEVELS; j++) begin : g_lvl
        localparam int N_OUT = P2 >> j;
        logic [RES_W-1:0] w_cmp [0:P2-1];

        // Each group of four vectors from the previous level becomes a sum/carry pair.
        always_comb begin
            for (int p = 0; p < P2; p++) w_cmp[p] = '0;
            for (int p = 0; p < N_OUT / 2; p++) begin
                w_cmp[2*p]   = csa42_sum(w_stage[j-1][4*p], w_stage[j-1][4*p+1],
                                         w_stage[j-1][4*p+2], w_stage[j-1][4*p+3]);
                w_cmp[2*p+1] = csa42_carry(w_stage[j-1][4*p], w_stage[j-1][4*p+1],
                                           w_stage[j-1][4*p+2], w_stage[j-1][4*p+3]);
            end
        end

        if (((j % PIPE_EVERY) == 0) || (j == LEVELS)) begin : g_reg
            logic [RES_W-1:0] r_bank [0:P2-1];
            logic             r_vld;
            logic             r_lst;
            logic             r_sgn;

            // Tree register bank with its valid/last/mode side-band; holds while en=0.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int p = 0; p < P2; p++) r_bank[p] <= '0;
                    r_vld <= 1'b0;
                    r_lst <= 1'b0;
                    r_sgn <= 1'b0;
                end else if (en) begin
                    for (int p = 0; p < P2; p++) r_bank[p] <= w_cmp[p];
                    r_vld <= w_vld[j-1];
                    r_lst <= w_lst[j-1];
                    r_sgn <= w_sgn[j-1];
                end
            end

            for (genvar i = 0; i < P2; i++) begin : g_o
                assign w_stage[j][i] = r_bank[i];
            end
            assign w_vld[j] = r_vld;
            assign w_lst[j] = r_lst;
            assign w_sgn[j] = r_sgn;
        end else begin : g_comb
            for (genvar i = 0; i < P2; i++) begin : g_o
                assign w_stage[j][i] = w_cmp[i];
            end
            assign w_vld[j] = w_vld[j-1];
            assign w_lst[j] = w_lst[j-1];
            assign w_sgn[j] = w_sgn[j-1];
        end
    end

    logic [RES_W-1:0] r_sum;
    logic             r_cpa_vld;
    logic             r_cpa_lst;
    logic             r_cpa_sgn;

    // Carry-propagate adder on the final two tree vectors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum     <= '0;
            r_cpa_vld <= 1'b0;
            r_cpa_lst <= 1'b0;
            r_cpa_sgn <= 1'b0;
        end else if (en) begin
            r_sum     <= w_stage[LEVELS][0] + w_stage[LEVELS][1];
            r_cpa_vld <= w_vld[LEVELS];
            r_cpa_lst <= w_lst[LEVELS];
            r_cpa_sgn <= w_sgn[LEVELS];
        end
    end

    logic [RES_W-1:0] r_acc;
    logic [7:0]       r_cnt;
    logic             r_sticky;
    logic             r_in_grp;
    logic             r_grp_sgn;
    logic             r_out_valid;
    logic [RES_W-1:0] r_result;
    logic [LZ_W-1:0]  r_lz;
    logic             r_ovf;
    logic [7:0]       r_beat_cnt;

    logic [RES_W-1:0] w_acc_next;
    logic             w_carry;
    logic             w_grp_sgn;
    logic             w_ovf_now;
    logic             w_sticky_next;
    logic [7:0]       w_cnt_next;
    logic [LZ_W-1:0]  w_lz;

    // Accumulate the current beat; the group's mode is fixed by its first beat.
    always_comb begin
        w_grp_sgn = r_cpa_sgn;
        if (r_in_grp) w_grp_sgn = r_grp_sgn;
        else          w_grp_sgn = r_cpa_sgn;
        {w_carry, w_acc_next} = {1'b0, r_acc} + {1'b0, r_sum};
        w_ovf_now = 1'b0;
        if (w_grp_sgn) w_ovf_now = (r_acc[RES_W-1] == r_sum[RES_W-1]) &&
                                   (w_acc_next[RES_W-1] != r_acc[RES_W-1]);
        else           w_ovf_now = w_carry;
        w_sticky_next = r_sticky | w_ovf_now;
        w_cnt_next    = r_cnt;
        if (r_cnt == 8'd255) w_cnt_next = 8'd255;
        else                 w_cnt_next = r_cnt + 8'd1;
        w_lz = lead_count(w_acc_next, w_grp_sgn);
    end

    // Group accumulator and result registers; everything clears after a last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_cnt       <= 8'd0;
            r_sticky    <= 1'b0;
            r_in_grp    <= 1'b0;
            r_grp_sgn   <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_lz        <= '0;
            r_ovf       <= 1'b0;
            r_beat_cnt  <= 8'd0;
        end else if (en) begin
            r_out_valid <= 1'b0;
            if (r_cpa_vld) begin
                if (r_cpa_lst) begin
                    r_out_valid <= 1'b1;
                    r_result    <= w_acc_next;
                    r_lz        <= w_lz;
                    r_ovf       <= w_sticky_next;
                    r_beat_cnt  <= w_cnt_next;
                    r_acc       <= '0;
                    r_cnt       <= 8'd0;
                    r_sticky    <= 1'b0;
                    r_in_grp    <= 1'b0;
                end else begin
                    r_acc       <= w_acc_next;
                    r_cnt       <= w_cnt_next;
                    r_sticky    <= w_sticky_next;
                    r_in_grp    <= 1'b1;
                    r_grp_sgn   <= w_grp_sgn;
                end
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.lz_out    = r_lz;
    assign bus.overflow  = r_ovf;
    assign bus.beat_cnt  = r_beat_cnt;
endmodule

// File: doc/csa_tree_accum.md
Name: csa_tree_accum

Overview:
- Parametrised successor to the fixed 32-input CSA reduction tree used by the FPU datapath.
- Accepts any operand count (zero-padded to the next power of two) and signed or unsigned operands.
- Pipeline register placement is configurable; valid is tracked through the pipe.
- Adds a group accumulator: tree sums of consecutive beats are summed until a last-beat flag. One result per group is emitted, with a leading-zero/sign count and an overflow flag.

Parameters:
- OP_WIDTH, 27: width of each operand.
- OP_NUM, 32: number of operands, 2..64. Not restricted to powers of two.
- PIPE_EVERY, 1: insert a register bank after every PIPE_EVERY 4:2 levels (1..8). The last level is always registered.
- ACC_EXT, 4: extra accumulator guard bits.
- Derived, P2 = 2^ceil(log2(OP_NUM)): padded operand count.
- Derived, LEVELS = log2(P2)-1: number of 4:2 levels.
- Derived, STG = ceil(LEVELS/PIPE_EVERY): number of tree register banks.
- Derived, RES_W = OP_WIDTH+log2(P2)+ACC_EXT: result and accumulator width.
- Derived, LZ_W = ceil(log2(RES_W+1)): width of the leading count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global advance. When 0, every register holds, including the valid pipe.
- in_valid  in  1  ops_in carries a beat.
- in_last  in  1  the beat closes the current accumulation group.
- signed_mode  in  1  1 = operands are two's complement. Sampled with each beat and travels with it.
- ops_in  in  OP_NUM*OP_WIDTH  operands. Operand i occupies bits [i*OP_WIDTH +: OP_WIDTH].
- out_valid  out  1  one-cycle pulse: a group result is present.
- result  out  RES_W  accumulated group sum.
- lz_out  out  LZ_W  leading count of result.
- overflow  out  1  the group sum wrapped.
- beat_cnt  out  8  number of beats in the emitted group, saturating at 255.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, result=0, lz_out=0, overflow=0, beat_cnt=0. Accumulator, beat counter and all valid bits are cleared. Pipe data registers are cleared too. A reset mid-group discards the partial group, and no out_valid follows.
- Extension: operands are extended to RES_W.
  - signed_mode=1: sign-extended.
  - signed_mode=0: zero-extended.
  - Pad operands OP_NUM..P2-1 are zero.
- Tree:
  - Level k uses 4:2 compressors of width RES_W.
  - Carries are truncated at RES_W, so arithmetic is modulo 2^RES_W.
  - After LEVELS levels two vectors remain; a carry-propagate adder sums them.
  - For P2=2 there are no tree levels; the CPA is fed directly.
- Pipeline:
  - Register banks follow level j (1-based) when j mod PIPE_EVERY = 0 or j = LEVELS.
  - Then: CPA output register, accumulator register.
  - Valid, last and signed_mode ride alongside in shift registers.
- Latency: out_valid is asserted exactly STG+2 en-cycles after the in_valid beat that carried in_last=1.
  - Default config: LEVELS=4, STG=4, latency 6.
- Accumulator, on each en cycle where the CPA-stage valid=1:
  - acc_next = (first beat of group ? 0 : acc) + sum.
  - The beat counter increments, saturating at 255.
  - If that beat's last=1: result<=acc_next, beat_cnt<=count, out_valid<=1, overflow<=sticky. Then the accumulator, counter and sticky clear.
  - Back-to-back groups need no idle cycle: the beat after a last beat starts a fresh group the same cycle.
- Overflow sticky:
  - Signed: set when the two addends share a sign and acc_next has the opposite sign.
  - Unsigned: set on carry out of bit RES_W-1.
  - The tree itself is sized so it cannot overflow.
- lz_out:
  - Unsigned group: number of leading zeros of result (RES_W when result=0).
  - Signed group: number of leading bits equal to the MSB, minus 1 (0..RES_W-1).
  - Computed combinationally from acc_next and registered with result.
- Mixing modes: signed_mode inside one group is taken from that group's first beat. Later beats of the group are extended per their own flag. This mixing is not a supported use.
- Bubbles: in_valid=0 cycles inside a group are allowed. They propagate as invalid beats and do not affect the accumulator.
- en=0 on an out_valid cycle: out_valid stays high and the result is held until the next en=1 cycle. out_valid is a pulse only in en-qualified time.
- in_last with in_valid=0 is ignored.

Test Plan:
- Default params, unsigned, all 32 operands = 1, in_valid=in_last=1 for one beat. Required: out_valid exactly 6 cycles later; result=32; beat_cnt=1; overflow=0; lz_out=RES_W-6=30 (RES_W=36).
- OP_NUM=5, PIPE_EVERY=2, signed, operands {-3,7,-1,0,2}, single beat. Required: result=5; latency STG+2=3; pad lanes contribute nothing.
- Accumulation group: 3 beats, all 32 operands = 2^26-1, in_last on beat 3 with one bubble between beats 2 and 3. Required: a single out_valid; result=96*(2^26-1); beat_cnt=3; no pulse for beats 1–2.
- Overflow, signed: 17 beats, each with all operands = max positive 2^26-1. Required: overflow=1 on the emitted result, and result equals the modulo-2^36 wrap of the sum. A following 1-beat group of zeros reports overflow=0 and lz_out=35.
- Stall and reset: drop en for 3 cycles mid-pipe. Required: out_valid delayed by exactly 3 cycles and data unchanged. Then assert rst_n=0 asynchronously mid-group. Required: outputs 0 immediately, and no out_valid for the aborted group after release.
- Back-to-back groups: two 1-beat groups on consecutive cycles with values 10 and -4 (signed). Required: out_valid on two consecutive cycles carrying 10 then -4, each with beat_cnt=1.
